// File: rtl/wb_stream_slave.sv
// Wishbone B4 pipelined slave that bridges a byte TX stream and a byte RX stream
// through two first-word-fall-through FIFOs, with STATUS/DATA/CTRL registers.
module wb_stream_slave #(
    parameter int unsigned WB_ADDR_WIDTH = 2,
    parameter int unsigned FIFO_AW       = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    output logic                     o_wb_stall,
    output logic                     o_wb_ack,
    input  logic                     i_wb_we,
    input  logic [WB_ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [31:0]              i_wb_data,
    input  logic [3:0]               i_wb_sel,
    output logic [31:0]              o_wb_data,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    input  logic [7:0]               i_rx_data,
    input  logic                     i_rx_valid,
    output logic                     o_rx_ready
);
    localparam logic [FIFO_AW:0]   CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    logic [7:0]         tx_mem [0:(1 << FIFO_AW) - 1];
    logic [7:0]         rx_mem [0:(1 << FIFO_AW) - 1];
    logic [FIFO_AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [FIFO_AW:0]   tx_cnt_q, rx_cnt_q, tx_cnt_d, rx_cnt_d;
    logic               ack_q;
    logic [31:0]        rdata_q, rdata_d;

    logic [1:0] reg_addr;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       accept, tx_push, tx_pop, rx_push, rx_pop, tx_flush, rx_flush;
    logic       unused_bits;

    assign reg_addr    = i_wb_addr[1:0];
    assign unused_bits = ^{i_wb_data[31:8], i_wb_sel[3:1], i_wb_addr};

    assign tx_full  = (tx_cnt_q == CNT_FULL);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CNT_FULL);
    assign rx_empty = (rx_cnt_q == '0);

    // Only a TX byte push into a full FIFO is held off; everything else completes.
    assign o_wb_stall = ~i_rst & i_wb_cyc & i_wb_stb & i_wb_we & (reg_addr == 2'd1)
                        & i_wb_sel[0] & tx_full;
    assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;

    assign o_tx_valid = ~i_rst & ~tx_empty;
    assign o_rx_ready = ~i_rst & ~rx_full;
    assign o_tx_data  = tx_mem[tx_rd_q];
    assign o_wb_ack   = ack_q & i_wb_cyc;
    assign o_wb_data  = rdata_q;

    assign tx_push  = accept & i_wb_we & (reg_addr == 2'd1) & i_wb_sel[0];
    assign tx_pop   = o_tx_valid & i_tx_ready;
    assign rx_push  = i_rx_valid & o_rx_ready;
    assign rx_pop   = accept & ~i_wb_we & (reg_addr == 2'd1) & ~rx_empty;
    assign rx_flush = accept & i_wb_we & (reg_addr == 2'd2) & i_wb_sel[0] & i_wb_data[0];
    assign tx_flush = accept & i_wb_we & (reg_addr == 2'd2) & i_wb_sel[0] & i_wb_data[1];

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop) begin
            tx_cnt_d = tx_cnt_q + CNT_ONE;
        end else if (!tx_push && tx_pop) begin
            tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop) begin
            rx_cnt_d = rx_cnt_q + CNT_ONE;
        end else if (!rx_push && rx_pop) begin
            rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (!i_wb_we) begin
            case (reg_addr)
                2'd0: begin
                    rdata_d[FIFO_AW:0]       = rx_cnt_q;
                    rdata_d[16+FIFO_AW:16]   = tx_cnt_q;
                end
                2'd1: begin
                    if (!rx_empty) begin
                        rdata_d = {1'b1, 23'b0, rx_mem[rx_rd_q]};
                    end
                end
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_q] <= i_wb_data[7:0];
        end
        if (rx_push) begin
            rx_mem[rx_wr_q] <= i_rx_data;
        end
    end

    // A flush wins over any push or pop on the same FIFO in that cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_flush) begin
                tx_wr_q  <= '0;
                tx_rd_q  <= '0;
                tx_cnt_q <= '0;
            end else begin
                if (tx_push) tx_wr_q <= tx_wr_q + PTR_ONE;
                if (tx_pop)  tx_rd_q <= tx_rd_q + PTR_ONE;
                tx_cnt_q <= tx_cnt_d;
            end
            if (rx_flush) begin
                rx_wr_q  <= '0;
                rx_rd_q  <= '0;
                rx_cnt_q <= '0;
            end else begin
                if (rx_push) rx_wr_q <= rx_wr_q + PTR_ONE;
                if (rx_pop)  rx_rd_q <= rx_rd_q + PTR_ONE;
                rx_cnt_q <= rx_cnt_d;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= accept;
            if (accept) begin
                rdata_q <= rdata_d;
            end
        end
    end

endmodule

// File: tb/tb_wb_stream_slave.sv
// Bench for wb_stream_slave: a queue-level model compared every cycle, plus directed
// scenarios with literal expectations.
module tb_wb_stream_slave;
    localparam int FIFO_AW = 4;
    localparam int DEPTH   = 1 << FIFO_AW;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        cyc      = 1'b0;
    logic        stb      = 1'b0;
    logic        we       = 1'b0;
    logic [1:0]  addr     = 2'd0;
    logic [31:0] wdata    = 32'h0;
    logic [3:0]  sel      = 4'h0;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data  = 8'h0;
    logic        rx_valid = 1'b0;

    logic        stall, ack, tx_valid, rx_ready;
    logic [31:0] rdata;
    logic [7:0]  tx_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic        m_ack  = 1'b0;
    logic [31:0] m_data = 32'h0;
    logic [7:0]  tx_log[$];
    logic [31:0] rd_log[$];

    wb_stream_slave #(
        .WB_ADDR_WIDTH(2),
        .FIFO_AW      (FIFO_AW)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wb_cyc  (cyc),
        .i_wb_stb  (stb),
        .o_wb_stall(stall),
        .o_wb_ack  (ack),
        .i_wb_we   (we),
        .i_wb_addr (addr),
        .i_wb_data (wdata),
        .i_wb_sel  (sel),
        .o_wb_data (rdata),
        .o_tx_data (tx_data),
        .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready),
        .i_rx_data (rx_data),
        .i_rx_valid(rx_valid),
        .o_rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] rd_at(input int i);
        return (i < rd_log.size()) ? rd_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] tx_at(input int i);
        return (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hDEAD_BEEF;
    endfunction

    // Model: FIFOs as queues, register file rules applied per accepted request.
    always @(posedge clk) begin
        logic        acc, stall_m, rx_hs;
        logic [31:0] nd;
        if (rst) begin
            tx_q.delete();
            rx_q.delete();
            m_ack  = 1'b0;
            m_data = 32'h0;
        end else begin
            stall_m = cyc && stb && we && addr == 2'd1 && sel[0] && tx_q.size() == DEPTH;
            acc     = cyc && stb && !stall_m;
            nd      = m_data;
            if (acc) begin
                nd = 32'h0;
                if (!we && addr == 2'd0) begin
                    nd = 32'(rx_q.size()) | (32'(tx_q.size()) << 16);
                end else if (!we && addr == 2'd1 && rx_q.size() > 0) begin
                    nd = {24'h800000, rx_q[0]};
                end
            end
            if (tx_ready && tx_q.size() > 0) void'(tx_q.pop_front());
            if (acc && we && addr == 2'd1 && sel[0]) tx_q.push_back(wdata[7:0]);
            rx_hs = rx_valid && rx_q.size() < DEPTH;
            if (acc && !we && addr == 2'd1 && rx_q.size() > 0) void'(rx_q.pop_front());
            if (rx_hs) rx_q.push_back(rx_data);
            if (acc && we && addr == 2'd2 && sel[0]) begin
                if (wdata[0]) rx_q.delete();
                if (wdata[1]) tx_q.delete();
            end
            m_ack  = acc;
            m_data = nd;
        end
    end

    always @(negedge clk) begin
        logic exp_stall;
        exp_stall = !rst && cyc && stb && we && addr == 2'd1 && sel[0] && tx_q.size() == DEPTH;
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("tx_valid", 32'(tx_valid), 32'(!rst && tx_q.size() > 0));
        if (!rst && tx_q.size() > 0) chk("tx_data", 32'(tx_data), 32'(tx_q[0]));
        chk("rx_ready", 32'(rx_ready), 32'(!rst && rx_q.size() < DEPTH));
        chk("ack", 32'(ack), 32'(m_ack && cyc));
        if (m_ack && cyc) chk("rdata", rdata, m_data);
        if (ack) rd_log.push_back(rdata);
        if (!rst && tx_valid && tx_ready) tx_log.push_back(tx_data);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single request; entered and left one time unit after a rising edge.
    task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
        int n;
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        sel   = s;
        n     = 0;
        @(negedge clk);
        while (stall && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (stall) chk("xfer_stall_timeout", 32'(stall), 32'h0);
        @(posedge clk);
        #1;
        stb = 1'b0;
        @(negedge clk);
        rd = rdata;
        chk("xfer_ack", 32'(ack), 32'h1);
        @(posedge clk);
        #1;
        cyc = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        hs;
        int          got;

        rst = 1'b1;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_rx_ready", 32'(rx_ready), 32'h1);
        chk("post_reset_tx_valid", 32'(tx_valid), 32'h0);
        step(1);
        wb_xfer(1'b0, 2'd0, 32'h0, 4'hF, rd);
        chk("status_after_reset", rd, 32'h0000_0000);

        // TX fill to full, stall on the 17th byte, then drain.
        tx_ready = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 2'd1; sel = 4'h1;
        for (int i = 0; i < 16; i++) begin
            wdata = 32'(i);
            step(1);
        end
        wdata = 32'h10;
        @(negedge clk);
        chk("tx_full_stall", 32'(stall), 32'h1);
        step(1);
        stb = 1'b0;
        cyc = 1'b0;
        wb_xfer(1'b0, 2'd0, 32'h0, 4'hF, rd);
        chk("status_tx16", rd, 32'h0010_0000);
        tx_log.delete();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 2'd1; wdata = 32'h10; sel = 4'h1;
        tx_ready = 1'b1;
        @(negedge clk);
        chk("stall_with_pop", 32'(stall), 32'h1);
        chk("tx_head_first", 32'(tx_data), 32'h0);
        @(negedge clk);
        chk("stall_released", 32'(stall), 32'h0);
        @(posedge clk);
        #1;
        stb = 1'b0;
        step(1);
        cyc = 1'b0;
        step(20);
        chk("tx_stream_len", 32'(tx_log.size()), 32'd17);
        for (int i = 0; i < 17; i++) chk("tx_stream_order", tx_at(i), 32'(i));

        // Two RX bytes, DATA then STATUS back to back, then drain.
        rx_valid = 1'b1; rx_data = 8'hA5;
        step(1);
        rx_data = 8'h5A;
        step(1);
        rx_valid = 1'b0;
        rd_log.delete();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 2'd1; sel = 4'hF;
        step(1);
        addr = 2'd0;
        step(1);
        stb = 1'b0;
        step(1);
        cyc = 1'b0;
        chk("rx_read_a5", rd_at(0), 32'h8000_00A5);
        chk("status_after_pop", rd_at(1), 32'h0000_0001);
        wb_xfer(1'b0, 2'd1, 32'h0, 4'hF, rd);
        chk("rx_read_5a", rd, 32'h8000_005A);
        wb_xfer(1'b0, 2'd1, 32'h0, 4'hF, rd);
        chk("rx_read_empty", rd, 32'h0000_0000);
        wb_xfer(1'b0, 2'd0, 32'h0, 4'hF, rd);
        chk("status_rx0", rd, 32'h0000_0000);

        // RX fill to full, then pipelined reads with the stream still pushing.
        rx_valid = 1'b1;
        rx_data  = 8'h10;
        got      = 0;
        for (int k = 0; k < 40 && got < 16; k++) begin
            @(negedge clk);
            hs = rx_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                got++;
                rx_data++;
            end
        end
        @(negedge clk);
        chk("rx_full_not_ready", 32'(rx_ready), 32'h0);
        @(posedge clk);
        #1;
        rd_log.delete();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 2'd1; sel = 4'hF;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            hs = rx_ready && rx_valid;
            @(posedge clk);
            #1;
            if (hs) rx_data++;
        end
        stb      = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        cyc = 1'b0;
        chk("rx_reads_len", 32'(rd_log.size()), 32'd20);
        for (int i = 0; i < 20; i++) chk("rx_wrap_order", rd_at(i), 32'h8000_0010 + 32'(i));

        // Flush both FIFOs with a coincident RX byte.
        wb_xfer(1'b1, 2'd2, 32'h1, 4'h1, rd);
        tx_ready = 1'b0;
        rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rx_data = 8'(8'h30 + i);
            step(1);
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) wb_xfer(1'b1, 2'd1, 32'h41 + 32'(i), 4'h1, rd);
        wb_xfer(1'b0, 2'd0, 32'h0, 4'hF, rd);
        chk("status_5rx_3tx", rd, 32'h0003_0005);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 2'd2; wdata = 32'h3; sel = 4'h1;
        rx_valid = 1'b1; rx_data = 8'hEE;
        step(1);
        stb = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("flush_tx_valid", 32'(tx_valid), 32'h0);
        step(1);
        cyc = 1'b0;
        wb_xfer(1'b0, 2'd0, 32'h0, 4'hF, rd);
        chk("status_after_flush", rd, 32'h0000_0000);

        // Writes that must have no effect, and zero-reading registers.
        wb_xfer(1'b1, 2'd1, 32'h99, 4'hE, rd);
        wb_xfer(1'b1, 2'd0, 32'hFFFF_FFFF, 4'hF, rd);
        wb_xfer(1'b0, 2'd0, 32'h0, 4'hF, rd);
        chk("status_no_effect", rd, 32'h0000_0000);
        wb_xfer(1'b0, 2'd2, 32'h0, 4'hF, rd);
        chk("ctrl_reads_zero", rd, 32'h0000_0000);
        wb_xfer(1'b1, 2'd3, 32'h1234_5678, 4'hF, rd);
        wb_xfer(1'b0, 2'd3, 32'h0, 4'hF, rd);
        chk("addr3_reads_zero", rd, 32'h0000_0000);

        // Master drops cyc right after the accept.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 2'd0; sel = 4'hF;
        step(1);
        cyc = 1'b0;
        stb = 1'b0;
        @(negedge clk);
        chk("ack_masked_by_cyc", 32'(ack), 32'h0);
        step(1);

        // Reset with 8 TX bytes queued and a request in flight.
        for (int i = 0; i < 8; i++) wb_xfer(1'b1, 2'd1, 32'h80 + 32'(i), 4'h1, rd);
        wb_xfer(1'b0, 2'd0, 32'h0, 4'hF, rd);
        chk("status_tx8", rd, 32'h0008_0000);
        rst = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 2'd0; sel = 4'hF;
        @(negedge clk);
        chk("in_reset_tx_valid", 32'(tx_valid), 32'h0);
        chk("in_reset_rx_ready", 32'(rx_ready), 32'h0);
        step(1);
        rst = 1'b0;
        stb = 1'b0;
        @(negedge clk);
        chk("no_ack_after_reset", 32'(ack), 32'h0);
        chk("after_reset_tx_valid", 32'(tx_valid), 32'h0);
        chk("after_reset_rx_ready", 32'(rx_ready), 32'h1);
        step(1);
        cyc = 1'b0;
        wb_xfer(1'b0, 2'd0, 32'h0, 4'hF, rd);
        chk("status_after_pulse", rd, 32'h0000_0000);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
